// File: rtl/rr_arb_mux.sv
// Round-robin arbiter + payload mux into a one-entry output register; RR_ARB_LOCK_EN adds per-requester packet lock.
// Latency 1 cycle accept->out_valid; req_ready is all-zero while the output beat is stalled by out_ready.
module rr_arb_mux #(
  parameter int REQ_NUM    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQ_NUM-1:0]            req_valid,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] req_data,
`ifdef RR_ARB_LOCK_EN
  input  logic [REQ_NUM-1:0]            req_lock,
`endif
  output logic [REQ_NUM-1:0]            req_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]              out_idx
);

  logic [IDX_W-1:0]      last_idx_q, last_idx_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]      out_idx_q, out_idx_d;

  logic [REQ_NUM-1:0]    last_oh, hi_mask, elig, hi_req, gnt;
  logic [IDX_W-1:0]      lo_idx, hi_idx, win_idx;
  logic                  win_vld, load, accept;
  logic [DATA_WIDTH-1:0] win_data;

  always_comb begin
    last_oh = '0;
    hi_mask = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      last_oh[i] = (last_idx_q == IDX_W'(i));
      hi_mask[i] = (IDX_W'(i) > last_idx_q);
    end
  end

`ifdef RR_ARB_LOCK_EN
  logic locked_q, locked_d;

  // A locked requester keeps the slot; everyone else is masked out.
  assign elig = locked_q ? (req_valid & last_oh) : req_valid;
`else
  assign elig = req_valid;
`endif

  assign hi_req = elig & hi_mask;
  assign load   = ~out_valid_q | out_ready;

  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (elig[i])   lo_idx = IDX_W'(i);
      if (hi_req[i]) hi_idx = IDX_W'(i);
    end
    win_vld = |elig;
    win_idx = (|hi_req) ? hi_idx : lo_idx;
  end

  always_comb begin
    gnt      = '0;
    win_data = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (win_vld && (win_idx == IDX_W'(i))) begin
        gnt[i]   = 1'b1;
        win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign req_ready = gnt & {REQ_NUM{load}};
  assign accept    = load & win_vld;

  always_comb begin
    last_idx_d  = last_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    if (load) begin
      out_valid_d = win_vld;
      if (win_vld) begin
        out_data_d = win_data;
        out_idx_d  = win_idx;
        last_idx_d = win_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_idx_q  <= IDX_W'(REQ_NUM - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      last_idx_q  <= last_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
    end
  end

`ifdef RR_ARB_LOCK_EN
  // The lock bit of every accepted beat decides whether the next beat stays with this requester.
  always_comb begin
    locked_d = locked_q;
    if (accept) locked_d = |(req_lock & gnt);
  end

  always_ff @(posedge clk) begin
    if (rst) locked_q <= 1'b0;
    else     locked_q <= locked_d;
  end
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed vector table, lock sequence (RR_ARB_LOCK_EN) and random traffic vs a rotating-pointer model.
`timescale 1ns/1ps
module tb_rr_arb_mux;
  localparam int N = 4;
  localparam int W = 8;
`ifdef RR_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, req_lock;
  logic [N*W-1:0] req_data;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_idx;

  int total = 0;
  int bad   = 0;

  bit           m_ov, m_locked;
  logic [W-1:0] m_od;
  int           m_oidx, m_last;

  logic [N-1:0] s_rdy;
  logic         s_ov;
  logic [1:0]   s_idx;
  logic [W-1:0] s_dat;

  typedef struct {
    logic [N-1:0] vld;
    logic         ordy;
    logic         rst;
    logic [N-1:0] e_rdy;
    logic         e_ov;
    logic [1:0]   e_idx;
  } vec_t;
  vec_t tbl[25];

  always #5 clk = ~clk;

  rr_arb_mux #(.REQ_NUM(N), .DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef RR_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_ov = 0; m_od = '0; m_oidx = 0; m_last = N - 1; m_locked = 0;
  endtask

  // Winner = first valid requester found walking forward from the last winner.
  function automatic int pick(input logic [N-1:0] v);
    if (m_locked) return v[m_last] ? m_last : -1;
    for (int k = 1; k <= N; k++) begin
      if (v[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle(input logic [N-1:0] v, input logic ordy, input logic r, input logic [N-1:0] lk);
    bit           ld;
    int           w;
    logic [N-1:0] exp_rdy;
    req_valid = v; out_ready = ordy; rst = r; req_lock = lk;
    #4;
    ld = !m_ov || ordy;
    w  = pick(v);
    exp_rdy = '0;
    if (ld && w >= 0) exp_rdy[w] = 1'b1;
    s_rdy = req_ready; s_ov = out_valid; s_idx = out_idx; s_dat = out_data;
    chk("model.rdy", 32'(req_ready), 32'(exp_rdy));
    chk("model.ov", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("model.data", 32'(out_data), 32'(m_od));
      chk("model.idx", 32'(out_idx), 32'(m_oidx));
    end
    @(posedge clk);
    if (r) m_reset();
    else if (ld) begin
      if (w >= 0) begin
        m_ov = 1; m_od = req_data[w*W +: W]; m_oidx = w; m_last = w;
        m_locked = LOCK_EN && (lk[w] == 1'b1);
      end else m_ov = 0;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_lock = '0; out_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.ov", 32'(out_valid), 32'd0);
    chk("reset.data", 32'(out_data), 32'd0);
    chk("reset.idx", 32'(out_idx), 32'd0);
    rst = 1'b0;
    req_data = 32'hA3A2A1A0;

    // all valid: 0,1,2,3,0,1,2,3
    tbl[0]  = '{4'hF, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0};
    tbl[1]  = '{4'hF, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0};
    tbl[2]  = '{4'hF, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1};
    tbl[3]  = '{4'hF, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd2};
    tbl[4]  = '{4'hF, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd3};
    tbl[5]  = '{4'hF, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0};
    tbl[6]  = '{4'hF, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1};
    tbl[7]  = '{4'hF, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd2};
    // 1010 alternates 1,3
    tbl[8]  = '{4'hA, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd3};
    tbl[9]  = '{4'hA, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd1};
    tbl[10] = '{4'hA, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd3};
    tbl[11] = '{4'hA, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd1};
    // load idx 2, stall 3 cycles, then release -> 3
    tbl[12] = '{4'h4, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd3};
    tbl[13] = '{4'hF, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[14] = '{4'hF, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[15] = '{4'hF, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[16] = '{4'hF, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd2};
    tbl[17] = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3};
    // single req 0 pulse, then all valid -> 1
    tbl[18] = '{4'h1, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0};
    tbl[19] = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[20] = '{4'hF, 1'b1, 1'b0, 4'b0010, 1'b0, 2'd0};
    tbl[21] = '{4'hF, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1};
    // reset with a beat held and last=2 -> first grant 0
    tbl[22] = '{4'hF, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2};
    tbl[23] = '{4'hF, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0};
    tbl[24] = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0};

    for (int i = 0; i < 25; i++) begin
      cycle(tbl[i].vld, tbl[i].ordy, tbl[i].rst, '0);
      chk($sformatf("tbl%0d.rdy", i), 32'(s_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d.ov", i), 32'(s_ov), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        chk($sformatf("tbl%0d.idx", i), 32'(s_idx), 32'(tbl[i].e_idx));
        chk($sformatf("tbl%0d.data", i), 32'(s_dat), 32'hA0 + 32'(tbl[i].e_idx));
      end
    end

`ifdef RR_ARB_LOCK_EN
    cycle(4'hF, 1'b1, 1'b1, 4'b0000);
    cycle(4'hF, 1'b1, 1'b0, 4'b0000);
    chk("lock.g0", 32'(s_rdy), 32'b0001);
    cycle(4'hF, 1'b1, 1'b0, 4'b0010);
    chk("lock.b1", 32'(s_rdy), 32'b0010);
    cycle(4'hF, 1'b1, 1'b0, 4'b0010);
    chk("lock.b2", 32'(s_rdy), 32'b0010);
    chk("lock.b2idx", 32'(s_idx), 32'd1);
    cycle(4'hF, 1'b1, 1'b0, 4'b0000);
    chk("lock.b3", 32'(s_rdy), 32'b0010);
    chk("lock.b3idx", 32'(s_idx), 32'd1);
    cycle(4'hF, 1'b1, 1'b0, 4'b0000);
    chk("lock.next", 32'(s_rdy), 32'b0100);
    chk("lock.nextidx", 32'(s_idx), 32'd1);
    cycle(4'h0, 1'b1, 1'b0, 4'b0000);
    chk("lock.lastidx", 32'(s_idx), 32'd2);
`endif

    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] lk;
      req_data = $urandom();
      lk = ($urandom_range(0, 3) == 0) ? N'($urandom()) : '0;
      cycle(N'($urandom()), ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0), lk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
